// File: rtl/cp0_unit.sv
// Coprocessor 0 for the 5-stage MIPS pipeline.
// Arbitrates hardware interrupts against M-stage exceptions. On an event it
// records SR/Cause/EPC and raises intexc to flush the pipeline. It also
// services mfc0/mtc0 and eret (EXL clear).
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h2018_1203
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        intexc,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        cause_bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  // EPC register
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] pc_word;
  logic [31:0] victim_epc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic        sr_write;
  logic        epc_write;
  logic        unused_pc_lsbs;

  // Only word-aligned PCs are recorded; the byte offset is dropped.
  assign unused_pc_lsbs = ^PC[1:0];

  // Event arbitration: interrupts outrank exceptions, and EXL blocks both.
  always_comb begin
    int_req = ie & ~exl & (|(HWInt & im));
    exc_req = ~exl & (ExcCode != 5'd0);
    intexc  = int_req | exc_req;
  end

  // Victim PC: a delay-slot instruction restarts at its branch.
  always_comb begin
    pc_word    = {PC[31:2], 2'b00};
    victim_epc = BD ? (pc_word - 32'd4) : pc_word;
    sr_write   = WE & ~intexc & (A2 == 5'd12);
    epc_write  = WE & ~intexc & (A2 == 5'd14);
  end

  // SR: event sets EXL; mtc0 writes IM/EXL/IE; eret clears EXL last so it
  // wins over a same-cycle mtc0 to SR while IM/IE still take DIn.
  always_ff @(posedge clk) begin
    if (reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else if (intexc) begin
      exl <= 1'b1;
    end else begin
      if (sr_write) begin
        im  <= DIn[15:10];
        exl <= DIn[1];
        ie  <= DIn[0];
      end
      if (EXLClr) begin
        exl <= 1'b0;
      end
    end
  end

  // Cause: IP tracks the interrupt lines every cycle; BD/ExcCode load on events.
  always_ff @(posedge clk) begin
    if (reset) begin
      ip       <= '0;
      cause_bd <= 1'b0;
      exc_code <= '0;
    end else begin
      ip <= HWInt;
      if (intexc) begin
        cause_bd <= BD;
        exc_code <= int_req ? 5'd0 : ExcCode;
      end
    end
  end

  // EPC: loaded with the victim PC on events, or by mtc0 when no event.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc <= '0;
    end else if (intexc) begin
      epc <= victim_epc;
    end else if (epc_write) begin
      epc <= {DIn[31:2], 2'b00};
    end
  end

  // Register views and mfc0 read mux (pre-edge values).
  always_comb begin
    sr_val    = {16'd0, im, 8'd0, exl, ie};
    cause_val = {cause_bd, 15'd0, ip, 3'd0, exc_code, 2'b00};
    case (A1)
      5'd12:   DOut = sr_val;
      5'd13:   DOut = cause_val;
      5'd14:   DOut = epc;
      5'd15:   DOut = PRID;
      default: DOut = '0;
    endcase
  end

  assign EPC = epc;

endmodule
